// File: rtl/tc_multi.sv
// tc_multi: N_CH independent down-counting timers on the device bus.
//   Each channel has one-shot and periodic auto-reload modes, an 8-bit prescaler,
//   a sticky write-1-to-clear pending flag and an interrupt mask.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   add_i    word address: [ADDR_WD-1:2] channel, [1:0] register
//   we_i     write strobe for the current cycle
//   dat_i    write data
//   dat_o    registered read data for add_i (1-cycle latency, pre-write value)
//   irq      OR of all unmasked pending flags
//   irq_vec  per-channel PEND & IM
// Register map per channel c:
//   4c+0 CTRL   [0]EN [2:1]MODE [3]IM [15:8]PSC
//   4c+1 PRESET
//   4c+2 COUNT  (read-only)
//   4c+3 STAT   [0]PEND (write 1 to clear)

// One timer channel. Owns its registers and produces its own read word.
module tc_multi_ch #(
  parameter int CNT_WD = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,    // write strobe, already qualified by channel select
  input  logic [1:0]  reg_i,
  input  logic [31:0] dat_i,
  output logic [31:0] rd_o,
  output logic        irq_o
);

  typedef struct packed {
    logic [7:0] psc;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] M_ONESHOT  = 2'b00;
  localparam logic [1:0] M_PERIODIC = 2'b01;

  ctrl_t              ctrl;
  logic [CNT_WD-1:0]  preset, count, cnt_nxt;
  logic [7:0]         pc, pc_nxt;
  logic               pend;
  logic               tick, wr_ctrl, wr_pre, wr_stat, pend_set, os_clr;

  assign wr_ctrl = wr_i && (reg_i == 2'd0);
  assign wr_pre  = wr_i && (reg_i == 2'd1);
  assign wr_stat = wr_i && (reg_i == 2'd3);
  assign tick    = ctrl.en && (pc == ctrl.psc);

  always_comb begin
    cnt_nxt  = count;
    pend_set = 1'b0;
    os_clr   = 1'b0;
    if (tick) begin
      case (ctrl.mode)
        M_ONESHOT: begin
          if (count > CNT_WD'(1)) cnt_nxt = count - CNT_WD'(1);
          else if (count == CNT_WD'(1)) begin
            cnt_nxt  = '0;
            pend_set = 1'b1;
            os_clr   = 1'b1;
          end
        end
        M_PERIODIC: begin
          // count of 0 reloads silently, so PRESET=0 idles with no interrupt
          if (count > CNT_WD'(1)) cnt_nxt = count - CNT_WD'(1);
          else begin
            cnt_nxt  = preset;
            pend_set = (count == CNT_WD'(1));
          end
        end
        default: ; // reserved modes hold
      endcase
    end
    // a PRESET write discards everything the same-cycle tick would have done
    if (wr_pre) begin
      cnt_nxt  = dat_i[CNT_WD-1:0];
      pend_set = 1'b0;
      os_clr   = 1'b0;
    end
  end

  always_comb begin
    if (wr_pre || !ctrl.en || tick) pc_nxt = '0;
    else                            pc_nxt = pc + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      pc     <= '0;
      pend   <= 1'b0;
    end else begin
      count <= cnt_nxt;
      pc    <= pc_nxt;
      // an explicit CTRL write beats the one-shot auto-clear of EN
      if (wr_ctrl)     ctrl <= '{psc: dat_i[15:8], im: dat_i[3], mode: dat_i[2:1], en: dat_i[0]};
      else if (os_clr) ctrl.en <= 1'b0;
      if (wr_pre) preset <= dat_i[CNT_WD-1:0];
      // set wins over a same-cycle clear so no expiry is lost
      if (pend_set)                 pend <= 1'b1;
      else if (wr_stat && dat_i[0]) pend <= 1'b0;
    end
  end

  always_comb begin
    case (reg_i)
      2'd0:    rd_o = {16'h0, ctrl.psc, 4'h0, ctrl.im, ctrl.mode, ctrl.en};
      2'd1:    rd_o = 32'(preset);
      2'd2:    rd_o = 32'(count);
      default: rd_o = {31'h0, pend};
    endcase
  end

  assign irq_o = pend & ctrl.im;

endmodule

module tc_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_WD  = 32,
  parameter int ADDR_WD = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_WD-1:0] add_i,
  input  logic               we_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               irq,
  output logic [N_CH-1:0]    irq_vec
);

  localparam int CH_W = ADDR_WD - 2;

  logic [CH_W-1:0]          ch_sel;
  logic [1:0]               reg_sel;
  logic [N_CH-1:0][31:0]    rd_word;
  logic [31:0]              rd_val;

  assign ch_sel  = add_i[ADDR_WD-1:2];
  assign reg_sel = add_i[1:0];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tc_multi_ch #(.CNT_WD(CNT_WD)) u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .wr_i  (we_i && (ch_sel == CH_W'(c))),
      .reg_i (reg_sel),
      .dat_i (dat_i),
      .rd_o  (rd_word[c]),
      .irq_o (irq_vec[c])
    );
  end

  // unmapped channel indices match no channel and read 0
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch_sel == CH_W'(i)) rd_val = rd_word[i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dat_o <= '0;
    else       dat_o <= rd_val;
  end

  assign irq = |irq_vec;

endmodule
